// File: rtl/gate_test_seq_if.sv
// Handshake and result bundle between a bench controller (master) and the
// gate_test_seq sequencer (slave). N_IN must match the sequencer's N_IN.
interface gate_test_seq_if #(
  parameter int N_IN = 2
) ();
  logic            start;
  logic            abort;
  logic [N_IN-1:0] vec_o;
  logic            dut_c_i;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   err_count;
  logic            fail_seen;
  logic [N_IN-1:0] first_fail;

  // The master side owns the run controls and feeds back the gate output.
  modport master (
    output start, abort, dut_c_i,
    input  vec_o, busy, done, pass, err_count, fail_seen, first_fail
  );

  modport slave (
    input  start, abort, dut_c_i,
    output vec_o, busy, done, pass, err_count, fail_seen, first_fail
  );
endinterface

// File: rtl/gate_test_seq.sv
// Exhaustive stimulus sequencer for a combinational gate: walks every input
// vector, waits a settle interval, checks against a truth table, reports.
module gate_test_seq #(
  parameter int                N_IN          = 2,
  parameter logic [2**N_IN-1:0] EXPECTED     = 4'b1000,
  parameter int                SETTLE_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  gate_test_seq_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    SETTLE,
    CHECK,
    DONE
  } state_t;

  localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE_CYCLES);
  localparam logic [N_IN-1:0] LAST_VEC    = {N_IN{1'b1}};

  state_t          state_q, state_d;
  logic [3:0]      settle_cnt;
  logic [N_IN-1:0] vec_q;
  logic [N_IN:0]   err_q;
  logic            fail_seen_q;
  logic [N_IN-1:0] first_fail_q;
  logic            pass_q;
  logic            busy_w;
  logic            mismatch;

  assign busy_w   = (state_q == APPLY) || (state_q == SETTLE) || (state_q == CHECK);
  assign mismatch = (bus.dut_c_i != EXPECTED[vec_q]);

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: state_d gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (bus.start) state_d = APPLY;
      APPLY: begin
        if (bus.abort)              state_d = IDLE;
        else if (SETTLE_CYCLES > 0) state_d = SETTLE;
        else                        state_d = CHECK;
      end
      SETTLE: begin
        if (bus.abort)                      state_d = IDLE;
        else if (settle_cnt == SETTLE_LAST) state_d = CHECK;
      end
      CHECK: begin
        if (bus.abort)             state_d = IDLE;
        else if (vec_q == LAST_VEC) state_d = DONE;
        else                       state_d = APPLY;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt   <= '0;
      vec_q        <= '0;
      err_q        <= '0;
      fail_seen_q  <= 1'b0;
      first_fail_q <= '0;
      pass_q       <= 1'b0;
    end else if (busy_w && bus.abort) begin
      // Partial error information is kept for post-mortem inspection.
      vec_q  <= '0;
      pass_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            vec_q        <= '0;
            err_q        <= '0;
            fail_seen_q  <= 1'b0;
            first_fail_q <= '0;
            pass_q       <= 1'b0;
          end
        end
        APPLY:  settle_cnt <= 4'd1;
        SETTLE: settle_cnt <= settle_cnt + 4'd1;
        CHECK: begin
          if (mismatch) begin
            err_q <= err_q + (N_IN+1)'(1);
            if (!fail_seen_q) begin
              fail_seen_q  <= 1'b1;
              first_fail_q <= vec_q;
            end
          end
          if (vec_q != LAST_VEC) vec_q <= vec_q + N_IN'(1);
        end
        DONE:    pass_q <= (err_q == '0);
        default: ;
      endcase
    end
  end

  assign bus.vec_o      = vec_q;
  assign bus.busy       = busy_w;
  assign bus.done       = (state_q == DONE);
  assign bus.pass       = pass_q;
  assign bus.err_count  = err_q;
  assign bus.fail_seen  = fail_seen_q;
  assign bus.first_fail = first_fail_q;

endmodule

// File: tb/tb_gate_test_seq.sv
// Directed bench for gate_test_seq: a 2-input instance with selectable gate
// behaviour and a 3-input AND instance with no settle interval.
module tb_gate_test_seq;

  logic clk;
  logic rst_n;
  int   gate_sel;   // 0 = AND, 1 = stuck at 0, 2 = OR
  int   tests;
  int   failed;

  gate_test_seq_if #(.N_IN(2)) bus_a ();
  gate_test_seq_if #(.N_IN(3)) bus_b ();

  gate_test_seq #(.N_IN(2), .EXPECTED(4'b1000), .SETTLE_CYCLES(2)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  gate_test_seq #(.N_IN(3), .EXPECTED(8'h80), .SETTLE_CYCLES(0)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  assign bus_a.dut_c_i = (gate_sel == 0) ? (bus_a.vec_o[1] & bus_a.vec_o[0]) :
                         (gate_sel == 1) ? 1'b0 :
                                           (bus_a.vec_o[1] | bus_a.vec_o[0]);
  assign bus_b.dut_c_i = &bus_b.vec_o;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [10:0] status_a();
    return {bus_a.vec_o, bus_a.busy, bus_a.done, bus_a.pass, bus_a.err_count,
            bus_a.fail_seen, bus_a.first_fail};
  endfunction

  // Starts a run on instance A and watches 20 cycles; optional start re-pulses.
  task automatic run_a(input int p1, input int p2,
                       output int done_at, output int busy_n, output int vec_bad);
    int exp_vec;
    done_at = 0; busy_n = 0; vec_bad = 0;
    @(negedge clk); bus_a.start = 1'b1;
    @(posedge clk); #1 bus_a.start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (bus_a.done === 1'b1 && done_at == 0) done_at = c;
      if (bus_a.busy === 1'b1) busy_n++;
      exp_vec = (c > 16) ? 3 : (c - 1) / 4;
      if (bus_a.vec_o !== 2'(exp_vec)) vec_bad++;
      bus_a.start = (c == p1) || (c == p2);
    end
    bus_a.start = 1'b0;
  endtask

  task automatic test_reset();
    tests++;
    if (status_a() !== 11'd0) begin
      failed++; $display("FAIL reset_status got %b want %b", status_a(), 11'd0);
    end
    tests++;
    if ({bus_b.vec_o, bus_b.busy, bus_b.done, bus_b.pass} !== 6'd0) begin
      failed++; $display("FAIL reset_b got %b want 0", {bus_b.vec_o, bus_b.busy, bus_b.done, bus_b.pass});
    end
  endtask

  task automatic test_and_pass();
    int d, b, v;
    gate_sel = 0;
    run_a(0, 0, d, b, v);
    tests++; if (d != 17) begin failed++; $display("FAIL and_done_cycle got %0d want 17", d); end
    tests++; if (b != 16) begin failed++; $display("FAIL and_busy_cycles got %0d want 16", b); end
    tests++; if (v != 0)  begin failed++; $display("FAIL and_vec_seq bad cycles %0d want 0", v); end
    tests++;
    if ({bus_a.pass, bus_a.err_count, bus_a.fail_seen} !== 5'b1_000_0) begin
      failed++; $display("FAIL and_result got %b want 10000", {bus_a.pass, bus_a.err_count, bus_a.fail_seen});
    end
  endtask

  task automatic test_stuck0();
    int d, b, v;
    gate_sel = 1;
    run_a(0, 0, d, b, v);
    tests++; if (d != 17) begin failed++; $display("FAIL stuck_done_cycle got %0d want 17", d); end
    tests++;
    if ({bus_a.pass, bus_a.err_count, bus_a.fail_seen, bus_a.first_fail} !== 7'b0_001_1_11) begin
      failed++; $display("FAIL stuck_result got %b want 0001111",
                         {bus_a.pass, bus_a.err_count, bus_a.fail_seen, bus_a.first_fail});
    end
  endtask

  task automatic test_or_gate();
    int d, b, v;
    gate_sel = 2;
    run_a(0, 0, d, b, v);
    tests++;
    if ({bus_a.pass, bus_a.err_count, bus_a.fail_seen, bus_a.first_fail} !== 7'b0_010_1_01) begin
      failed++; $display("FAIL or_result got %b want 0010101",
                         {bus_a.pass, bus_a.err_count, bus_a.fail_seen, bus_a.first_fail});
    end
  endtask

  task automatic test_abort();
    int d, b, v, done_n;
    gate_sel = 0;
    @(negedge clk); bus_a.start = 1'b1;
    @(posedge clk); #1 bus_a.start = 1'b0;
    for (int c = 1; c <= 6; c++) @(negedge clk);
    tests++; if (bus_a.vec_o !== 2'b01) begin failed++; $display("FAIL abort_pre_vec got %b want 01", bus_a.vec_o); end
    bus_a.abort = 1'b1;
    @(posedge clk); #1 bus_a.abort = 1'b0;
    @(negedge clk);
    tests++;
    if ({bus_a.busy, bus_a.vec_o, bus_a.pass, bus_a.err_count} !== 7'd0) begin
      failed++; $display("FAIL abort_state got %b want 0000000", {bus_a.busy, bus_a.vec_o, bus_a.pass, bus_a.err_count});
    end
    done_n = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus_a.done === 1'b1) done_n++;
    end
    tests++; if (done_n != 0) begin failed++; $display("FAIL abort_no_done got %0d pulses want 0", done_n); end
    run_a(0, 0, d, b, v);
    tests++;
    if (d != 17 || bus_a.pass !== 1'b1) begin
      failed++; $display("FAIL abort_rerun done %0d pass %b want 17 1", d, bus_a.pass);
    end
  endtask

  task automatic test_start_ignored();
    int d, b, v;
    gate_sel = 0;
    run_a(3, 10, d, b, v);
    tests++;
    if (d != 17 || b != 16 || v != 0) begin
      failed++; $display("FAIL restart_ignored done %0d busy %0d vec_bad %0d want 17 16 0", d, b, v);
    end
  endtask

  task automatic test_start_abort_together();
    gate_sel = 0;
    @(negedge clk); bus_a.start = 1'b1; bus_a.abort = 1'b1;
    @(posedge clk); #1 bus_a.start = 1'b0; bus_a.abort = 1'b0;
    @(negedge clk);
    tests++; if (bus_a.busy !== 1'b1) begin failed++; $display("FAIL start_wins busy %b want 1", bus_a.busy); end
    repeat (20) @(negedge clk);
    tests++; if (bus_a.pass !== 1'b1) begin failed++; $display("FAIL start_wins_pass got %b want 1", bus_a.pass); end
  endtask

  task automatic test_reset_mid();
    int done_n;
    gate_sel = 0;
    @(negedge clk); bus_a.start = 1'b1;
    @(posedge clk); #1 bus_a.start = 1'b0;
    for (int c = 1; c <= 8; c++) @(negedge clk);
    tests++; if (bus_a.busy !== 1'b1) begin failed++; $display("FAIL rst_mid_pre busy %b want 1", bus_a.busy); end
    rst_n = 1'b0;
    #1;
    tests++;
    if (status_a() !== 11'd0) begin failed++; $display("FAIL rst_mid_status got %b want %b", status_a(), 11'd0); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    done_n = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus_a.done === 1'b1 || bus_a.busy === 1'b1) done_n++;
    end
    tests++; if (done_n != 0) begin failed++; $display("FAIL rst_mid_quiet got %0d active cycles want 0", done_n); end
  endtask

  task automatic test_three_input();
    int done_at, busy_n, vec_bad, exp_vec;
    done_at = 0; busy_n = 0; vec_bad = 0;
    @(negedge clk); bus_b.start = 1'b1;
    @(posedge clk); #1 bus_b.start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (bus_b.done === 1'b1 && done_at == 0) done_at = c;
      if (bus_b.busy === 1'b1) busy_n++;
      exp_vec = (c > 16) ? 7 : (c - 1) / 2;
      if (bus_b.vec_o !== 3'(exp_vec)) vec_bad++;
    end
    tests++;
    if (done_at != 17 || busy_n != 16 || vec_bad != 0) begin
      failed++; $display("FAIL and3_timing done %0d busy %0d vec_bad %0d want 17 16 0", done_at, busy_n, vec_bad);
    end
    tests++;
    if ({bus_b.pass, bus_b.err_count, bus_b.fail_seen} !== 6'b1_0000_0) begin
      failed++; $display("FAIL and3_result got %b want 100000", {bus_b.pass, bus_b.err_count, bus_b.fail_seen});
    end
  endtask

  initial begin
    tests = 0; failed = 0; gate_sel = 0;
    rst_n = 1'b0;
    bus_a.start = 1'b0; bus_a.abort = 1'b0;
    bus_b.start = 1'b0; bus_b.abort = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_and_pass();
    test_stuck0();
    test_or_gate();
    test_abort();
    test_start_ignored();
    test_start_abort_together();
    test_reset_mid();
    test_three_input();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
